dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbitrates the single-port 2048×32 data memory between two requesters: the CPU load/store stage (port C) and the program/data loader (port D). It translates 32-bit byte addresses to word addresses, rejects illegal accesses, drives the memory port from registers, and returns read data on a per-port response channel. It sits between the pipeline/loader and the data memory wrapper, which samples on the falling edge of `clk`.

## Interface
- `DATA_W`, default 32: data width.
- `MEM_AW`, default 11: memory word-address width (depth 2^MEM_AW).
- `STARVE_LIMIT`, default 4: consecutive C grants allowed while D waits.
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `c_valid` in 1: C request valid; held with its fields until `c_ready`.
- `c_we` in 1: 1 = write, 0 = read.
- `c_addr` in 32: byte address.
- `c_wdata` in DATA_W: write data.
- `c_ready` out 1: combinational accept strobe.
- `c_rvalid` out 1: one-cycle response strobe.
- `c_rdata` out DATA_W: read data; 0 for writes and errors.
- `c_err` out 1: error flag, qualified by `c_rvalid`.
- `d_valid`, `d_we`, `d_addr`, `d_wdata`, `d_ready`, `d_rvalid`, `d_rdata`, `d_err`: same as port C, for port D.
- `mem_en` out 1: memory enable, registered.
- `mem_we` out 1: memory write enable, registered.
- `mem_addr` out MEM_AW: memory word address, registered.
- `mem_wdata` out DATA_W: memory write data, registered.
- `mem_rdata` in DATA_W: memory read data, valid before the rising edge that ends the ISSUE cycle.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE.** All memory outputs are 0.
  - If any `*_valid` is high, pick a winner, assert its `*_ready` in this cycle, latch port ID, `we`, address and wdata, then go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE.** Drive `mem_en=1` unless the latched request is illegal. `mem_we` = latched `we`; `mem_addr` = latched `addr[MEM_AW+1:2]`; `mem_wdata` = latched wdata. Always go to RESP.
- **RESP.**
  - Pulse the granted port's `*_rvalid` for one cycle. `*_rdata` is the captured `mem_rdata` for a legal read, else 0. `*_err` is set if the request was illegal.
  - Arbitrate in the same cycle as IDLE does. On a grant go to ISSUE, else go to IDLE.
- **Illegal request:** `addr[1:0] != 0` or `addr[31:MEM_AW+2] != 0`. It is accepted normally, the memory is not enabled, and the response carries `err=1`, `rdata=0`.
- **Arbitration** is fixed priority to C with an anti-starvation override.
  - `streak` counter, width clog2(STARVE_LIMIT+1).
  - A C grant while `d_valid=1` increments `streak`.
  - A D grant, or `d_valid=0`, clears `streak`.
  - If `d_valid=1` and `streak == STARVE_LIMIT`, D wins even if C is valid.
- Only one `*_ready` is asserted per cycle. A port not granted sees `ready=0` and must hold its request.
- Writes also produce a response (`rvalid=1`, `rdata=0`), so requesters can count completions.

## Timing
- Accept in cycle N (`ready=1`) → memory access in N+1 → `rvalid` in N+2.
- Throughput is one access per 2 cycles. Back-to-back operation is RESP→ISSUE→RESP…
- A response for one port and a grant for either port may occur in the same cycle.
- `mem_rdata` is captured at the rising edge that ends ISSUE, and is presented registered in RESP.
- **Reset** (asynchronous, any state):
  - State goes to IDLE and `streak` to 0.
  - All outputs go to 0 (`*_ready` = 0 while `rst` is high).
  - An in-flight access is dropped and no response is issued for it.
- After `rst` deasserts, the first grant may occur in the first cycle.
- If `*_valid` drops before a grant, the request is withdrawn and nothing happens. Dropping `valid` after a grant is legal.

## Structure
- Package `dmem_pkg` holds:
  - the state encoding (IDLE/ISSUE/RESP);
  - port ID constants (PORT_C=0, PORT_D=1);
  - `DMEM_AW=11` and `DMEM_DW=32`.
- One sub-module, `dmem_addr_check`: combinational byte address to word address plus illegal flag. It is instantiated once per port before the request latch.

## Test plan
- **Single read:** write 0xDEADBEEF to C@0x10, then read C@0x10. Required: `mem_addr=4`; `c_rvalid` 2 cycles after accept with `c_rdata=0xDEADBEEF`, `c_err=0`.
- **Illegal address:**
  - D reads 0x0000_0006 (misaligned). Required: `d_rvalid` with `d_err=1`, `d_rdata=0`, and `mem_en` never high.
  - Repeat for 0x0000_2000. Required: the same response.
- **Simultaneous requests, C preferred:** C and D both valid in the same cycle. Required: C granted first; D granted in C's RESP cycle; D's `rvalid` 2 cycles later.
- **Anti-starvation:** C and D valid continuously with STARVE_LIMIT=4. Required grant pattern C,C,C,C,D,C,C,C,C,D…
- **Reset mid-operation:** assert `rst` during ISSUE of a C write to 0x20. Required: all outputs 0 immediately and no `c_rvalid`. After release, reading 0x20 must be legal and complete normally with `c_err=0`, `rvalid` 2 cycles after accept. The data value is unspecified.
- **Back-to-back streaming:** 8 C writes, then 8 reads of addresses 0x0..0x1C. Required: `c_ready` every 2 cycles, and each read returns the value written.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM encoding, port IDs and default memory geometry.
package dmem_pkg;

   localparam int DMEM_AW = 11;
   localparam int DMEM_DW = 32;

   localparam logic PORT_C = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_addr_check.sv
// Byte address to word address translation plus legality flag.
// Illegal means misaligned or beyond the end of the memory.
module dmem_addr_check
   import dmem_pkg::*;
#(
   parameter int MEM_AW = DMEM_AW
) (
   input  logic [31:0]       byte_addr_i,
   output logic [MEM_AW-1:0] word_addr_o,
   output logic              illegal_o
);

   logic misaligned;
   logic out_of_range;

   // Split the byte address into its word index and the bits that must be zero
   always_comb begin
      word_addr_o  = byte_addr_i[MEM_AW+1:2];
      misaligned   = (byte_addr_i[1:0] != 2'b00);
      out_of_range = (byte_addr_i[31:MEM_AW+2] != '0);
      illegal_o    = misaligned | out_of_range;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Port C has priority; port D is protected by a starvation counter.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DATA_W       = DMEM_DW,
   parameter int MEM_AW       = DMEM_AW,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              c_valid,
   input  logic              c_we,
   input  logic [31:0]       c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_ready,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   output logic              c_err,

   input  logic              d_valid,
   input  logic              d_we,
   input  logic [31:0]       d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,

   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

   state_e              state_q, state_d;
   logic                port_q, port_d;
   logic                ill_q, ill_d;
   logic                we_q, we_d;
   logic [SW-1:0]       streak_q, streak_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

   logic [MEM_AW-1:0]   c_waddr, d_waddr;
   logic                c_ill, d_ill;
   logic                arb_en;
   logic                starve;
   logic                gnt_c, gnt_d;
   logic                sel_we, sel_ill;
   logic [MEM_AW-1:0]   sel_waddr;
   logic [DATA_W-1:0]   sel_wdata;
   logic                rsp_c, rsp_d;

   dmem_addr_check #(
      .MEM_AW (MEM_AW)
   ) u_chk_c (
      .byte_addr_i (c_addr),
      .word_addr_o (c_waddr),
      .illegal_o   (c_ill)
   );

   dmem_addr_check #(
      .MEM_AW (MEM_AW)
   ) u_chk_d (
      .byte_addr_i (d_addr),
      .word_addr_o (d_waddr),
      .illegal_o   (d_ill)
   );

   // Grant decision: C first unless D has waited through STARVE_LIMIT C grants
   always_comb begin
      arb_en    = !rst && (state_q != ST_ISSUE);
      starve    = d_valid && (streak_q == STREAK_MAX);
      gnt_d     = arb_en && d_valid && (!c_valid || starve);
      gnt_c     = arb_en && c_valid && !gnt_d;
      sel_we    = gnt_d ? d_we    : c_we;
      sel_ill   = gnt_d ? d_ill   : c_ill;
      sel_waddr = gnt_d ? d_waddr : c_waddr;
      sel_wdata = gnt_d ? d_wdata : c_wdata;
   end

   // Next state, request latch, memory port and streak update
   always_comb begin
      state_d     = state_q;
      port_d      = port_q;
      ill_d       = ill_q;
      we_d        = we_q;
      streak_d    = streak_q;
      rdata_d     = rdata_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;

      unique case (state_q)
         ST_IDLE: state_d = ST_IDLE;
         ST_ISSUE: begin
            state_d = ST_RESP;
            rdata_d = (!ill_q && !we_q) ? mem_rdata : '0;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (gnt_c || gnt_d) begin
         state_d     = ST_ISSUE;
         port_d      = gnt_d ? PORT_D : PORT_C;
         ill_d       = sel_ill;
         we_d        = sel_we;
         mem_en_d    = !sel_ill;
         mem_we_d    = sel_we;
         mem_addr_d  = sel_waddr;
         mem_wdata_d = sel_wdata;
      end

      if (!d_valid || gnt_d) begin
         streak_d = '0;
      end else if (gnt_c) begin
         streak_d = streak_q + SW'(1);
      end
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         port_q      <= PORT_C;
         ill_q       <= 1'b0;
         we_q        <= 1'b0;
         streak_q    <= '0;
         rdata_q     <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         port_q      <= port_d;
         ill_q       <= ill_d;
         we_q        <= we_d;
         streak_q    <= streak_d;
         rdata_q     <= rdata_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Response channel is live only in RESP for the port that owns the slot
   always_comb begin
      rsp_c    = (state_q == ST_RESP) && (port_q == PORT_C);
      rsp_d    = (state_q == ST_RESP) && (port_q == PORT_D);
      c_ready  = gnt_c;
      d_ready  = gnt_d;
      c_rvalid = rsp_c;
      d_rvalid = rsp_d;
      c_rdata  = rsp_c ? rdata_q : '0;
      d_rdata  = rsp_d ? rdata_q : '0;
      c_err    = rsp_c && ill_q;
      d_err    = rsp_d && ill_q;
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a falling-edge memory model.
// Responses are scored against a transaction-level reference memory.
module tb_dmem_arbiter;

   localparam int LIM = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        c_valid = 0, c_we = 0;
   logic [31:0] c_addr = 0, c_wdata = 0;
   logic        c_ready, c_rvalid, c_err;
   logic [31:0] c_rdata;
   logic        d_valid = 0, d_we = 0;
   logic [31:0] d_addr = 0, d_wdata = 0;
   logic        d_ready, d_rvalid, d_err;
   logic [31:0] d_rdata;
   logic        mem_en, mem_we;
   logic [10:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 0;

   int pass_cnt = 0;
   int tot_cnt  = 0;
   int cyc      = 0;

   dmem_arbiter #(
      .DATA_W       (32),
      .MEM_AW       (11),
      .STARVE_LIMIT (LIM)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .c_valid   (c_valid),
      .c_we      (c_we),
      .c_addr    (c_addr),
      .c_wdata   (c_wdata),
      .c_ready   (c_ready),
      .c_rvalid  (c_rvalid),
      .c_rdata   (c_rdata),
      .c_err     (c_err),
      .d_valid   (d_valid),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ready   (d_ready),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .d_err     (d_err),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // memory wrapper: samples on the falling edge
   logic [31:0] mem_model [2048];

   always @(negedge clk) begin
      if (mem_en) begin
         if (mem_we) mem_model[mem_addr] <= mem_wdata;
         else mem_rdata <= mem_model[mem_addr];
      end
   end

   // reference model: word array plus "value known" flags
   logic [31:0] ref_mem   [2048];
   bit          ref_known [2048];

   typedef struct {
      logic        port;
      int          cyc;
      logic        we;
      logic        legal;
      logic [10:0] widx;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      bit          known;
   } txn_t;

   txn_t sbq[$];

   function automatic txn_t model_accept(input logic p, input logic we,
                                         input logic [31:0] a,
                                         input logic [31:0] wd, input int c);
      txn_t t;
      t.port  = p;
      t.cyc   = c;
      t.we    = we;
      t.legal = (a % 4 == 0) && (a < 32'h2000);
      t.widx  = 11'(a / 4);
      t.wdata = wd;
      t.err   = !t.legal;
      t.rdata = 0;
      t.known = 1;
      if (t.legal && we) begin
         ref_mem[t.widx]   = wd;
         ref_known[t.widx] = 1;
      end else if (t.legal) begin
         t.rdata = ref_mem[t.widx];
         t.known = ref_known[t.widx];
      end
      return t;
   endfunction

   // scoreboard monitor, sampling mid-cycle
   always @(negedge clk) begin
      txn_t e;
      if (rst) begin
         foreach (sbq[i])
            if (sbq[i].legal && sbq[i].we) ref_known[sbq[i].widx] = 0;
         sbq.delete();
      end else begin
         if (mem_en) begin
            if (sbq.size() == 0) check("mem_en_spurious", 1, 0);
            else begin
               check("mem_en_legal", 32'(sbq[0].legal), 1);
               check("mem_addr", 32'(mem_addr), 32'(sbq[0].widx));
               check("mem_we", 32'(mem_we), 32'(sbq[0].we));
               if (sbq[0].we) check("mem_wdata", mem_wdata, sbq[0].wdata);
            end
         end
         if (c_ready && d_ready) check("one_ready", 1, 0);
         if (c_rvalid || d_rvalid) begin
            if (c_rvalid && d_rvalid) check("one_rvalid", 1, 0);
            if (sbq.size() == 0) check("rvalid_unexpected", 1, 0);
            else begin
               e = sbq.pop_front();
               check("rsp_port", 32'(d_rvalid), 32'(e.port));
               check("rsp_latency", 32'(cyc - e.cyc), 2);
               check("rsp_err", 32'(d_rvalid ? d_err : c_err), 32'(e.err));
               if (e.known)
                  check("rsp_rdata", d_rvalid ? d_rdata : c_rdata, e.rdata);
            end
         end
         if (c_valid && c_ready)
            sbq.push_back(model_accept(0, c_we, c_addr, c_wdata, cyc));
         if (d_valid && d_ready)
            sbq.push_back(model_accept(1, d_we, d_addr, d_wdata, cyc));
      end
   end

   task automatic set_req(input logic p, input logic v, input logic we,
                          input logic [31:0] a, input logic [31:0] wd);
      if (p) begin
         d_valid = v; d_we = we; d_addr = a; d_wdata = wd;
      end else begin
         c_valid = v; c_we = we; c_addr = a; c_wdata = wd;
      end
   endtask

   task automatic wait_ready(input logic p, input int bound, output bit got);
      got = 0;
      for (int n = 0; n < bound && !got; n++) begin
         @(negedge clk);
         got = p ? d_ready : c_ready;
      end
      if (!got) check("ready_timeout", 0, 1);
   endtask

   task automatic do_req(input logic p, input logic we,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
      bit got;
      @(posedge clk); #1;
      set_req(p, 1, we, a, wd);
      wait_ready(p, 20, got);
      @(posedge clk); #1;
      set_req(p, 0, 0, 0, 0);
      got = 0; rd = 0; er = 0;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk);
         if (p ? d_rvalid : c_rvalid) begin
            got = 1;
            rd  = p ? d_rdata : c_rdata;
            er  = p ? d_err : c_err;
         end
      end
      if (!got) check("rvalid_timeout", 0, 1);
   endtask

   task automatic rand_port(input logic p, input int n);
      bit got;
      logic [31:0] a;
      int r;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         a = 32'($urandom_range(0, 15)) * 4;
         r = $urandom_range(0, 9);
         if (r == 0) a = a | 32'($urandom_range(1, 3));
         if (r == 1) a = a | (32'h2000 << $urandom_range(0, 18));
         set_req(p, 1, 1'($urandom_range(0, 1)), a, $urandom);
         wait_ready(p, 60, got);
         @(posedge clk); #1;
         set_req(p, 0, 0, 0, 0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
   endtask

   typedef struct {
      logic        port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t tbl [9];

   initial begin
      logic [31:0] rd;
      logic        er;
      bit          got;
      int          acc [8];
      int          tc, td, rvc;
      logic [LIM:0] dummy;
      byte         grants [10];
      int          ng;

      for (int i = 0; i < 2048; i++) begin
         mem_model[i] = 0; ref_mem[i] = 0; ref_known[i] = 1;
      end

      tbl[0] = '{0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0};
      tbl[1] = '{0, 0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0};
      tbl[2] = '{1, 0, 32'h0000_0006, 32'h0, 32'h0, 1};
      tbl[3] = '{1, 0, 32'h0000_2000, 32'h0, 32'h0, 1};
      tbl[4] = '{1, 1, 32'h0000_1FFC, 32'h1234_5678, 32'h0, 0};
      tbl[5] = '{0, 0, 32'h0000_1FFC, 32'h0, 32'h1234_5678, 0};
      tbl[6] = '{0, 1, 32'h0000_0003, 32'h55, 32'h0, 1};
      tbl[7] = '{1, 0, 32'h8000_0010, 32'h0, 32'h0, 1};
      tbl[8] = '{1, 0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0};
      dummy = '0;

      // reset state, with requests pending
      c_valid = 1; d_valid = 1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'({c_ready, d_ready}), 0);
      check("rst_outs", 32'({mem_en, mem_we, c_rvalid, d_rvalid, c_err, d_err}), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      c_valid = 0; d_valid = 0;
      rst = 0;

      // single-transaction table
      foreach (tbl[i]) begin
         do_req(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, er);
         check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
         check($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      end

      // simultaneous requests: C first, D in C's response cycle
      @(posedge clk); #1;
      set_req(0, 1, 0, 32'h10, 0);
      set_req(1, 1, 0, 32'h1FFC, 0);
      @(negedge clk);
      check("sim_c_first", 32'({c_ready, d_ready}), 32'b10);
      tc = cyc;
      @(posedge clk); #1;
      set_req(0, 0, 0, 0, 0);
      wait_ready(1, 10, got);
      td = cyc;
      check("sim_d_gap", 32'(td - tc), 2);
      @(posedge clk); #1;
      set_req(1, 0, 0, 0, 0);
      repeat (4) @(posedge clk);

      // anti-starvation: both valid continuously
      @(posedge clk); #1;
      set_req(0, 1, 0, 32'h10, 0);
      set_req(1, 1, 0, 32'h14, 0);
      ng = 0;
      for (int n = 0; n < 60 && ng < 10; n++) begin
         @(negedge clk);
         if (c_ready) begin grants[ng] = "C"; ng++; end
         else if (d_ready) begin grants[ng] = "D"; ng++; end
      end
      @(posedge clk); #1;
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
      check("starve_count", 32'(ng), 10);
      for (int i = 0; i < 10; i++)
         check($sformatf("starve_g%0d", i), 32'(grants[i]),
               (i % (LIM + 1) == LIM) ? 32'("D") : 32'("C"));
      repeat (4) @(posedge clk);

      // reset during ISSUE of a C write
      @(posedge clk); #1;
      set_req(0, 1, 1, 32'h20, 32'hCAFE_F00D);
      wait_ready(0, 20, got);
      @(posedge clk); #2;
      rst = 1;
      #1;
      check("mrst_outs",
            32'({mem_en, mem_we, c_ready, c_rvalid, c_err, d_ready, d_rvalid}), 0);
      check("mrst_mem", 32'(mem_addr) | mem_wdata | c_rdata, 0);
      rvc = 0;
      repeat (2) begin
         @(negedge clk);
         if (c_rvalid || d_rvalid) rvc++;
      end
      @(posedge clk); #1;
      set_req(0, 0, 0, 0, 0);
      rst = 0;
      repeat (3) begin
         @(negedge clk);
         if (c_rvalid || d_rvalid) rvc++;
      end
      check("mrst_no_rvalid", 32'(rvc), 0);
      do_req(0, 0, 32'h20, 0, rd, er);
      check("mrst_read_err", 32'(er), 0);

      // back-to-back streaming: 8 writes then 8 reads
      for (int ph = 0; ph < 2; ph++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 8; i++) begin
            set_req(0, 1, (ph == 0), 32'(i * 4), 32'hA5A5_0000 + 32'(i * 7));
            wait_ready(0, 20, got);
            acc[i] = cyc;
            @(posedge clk); #1;
         end
         set_req(0, 0, 0, 0, 0);
         for (int i = 1; i < 8; i++)
            check($sformatf("stream%0d_gap%0d", ph, i),
                  32'(acc[i] - acc[i-1]), 2);
         repeat (4) @(posedge clk);
      end

      // randomized traffic on both ports
      fork
         rand_port(0, 40);
         rand_port(1, 40);
      join
      repeat (6) @(posedge clk);
      check("sb_drain", 32'(sbq.size()), 0);
      check("final_idle", 32'({c_ready, d_ready, mem_en}), 0);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
